// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix keymap, debounce FSM states and entry depth.
package keypad_pkg;

    localparam int MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } kp_state_t;

    // Indexed by {row, col}; * maps to E and # maps to F.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_input_btn_debounce.sv
// Button filter: two-flop synchronizer, then a level change is taken after BTN_CYCLES stable samples.
// Latency: 2 sync cycles + BTN_CYCLES; o_rise is a one-cycle pulse on the accepted rising edge.
module btn_debounce #(
    parameter int BTN_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = (BTN_CYCLES > 1) ? $clog2(BTN_CYCLES) : 1;

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            // r_cnt holds how many consecutive samples have disagreed with the accepted level, minus one
            if (r_sync != r_level) begin
                if (r_cnt == CW'(BTN_CYCLES - 1)) begin
                    r_level <= r_sync;
                    r_rise  <= r_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/keypad_input.sv
// 4x4 keypad scanner with frame-based debounce, 8-digit hex entry buffer and confirm/clear commit.
// Latency: key accepted DEBOUNCE_FRAMES frames after first sighting; buttons act 1 cycle after filter accept.
module keypad_input
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int BTN_CYCLES      = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  kp_col,
    input  logic        btn_confirm,
    input  logic        btn_clear,
    output logic [3:0]  kp_row,
    output logic [31:0] entry,
    output logic [3:0]  digit_cnt,
    output logic [3:0]  key_code,
    output logic        key_pulse,
    output logic [31:0] data_out,
    output logic        data_valid
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [3:0]    r_col_meta;
    logic [3:0]    r_col_sync;
    logic [1:0]    r_row;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_hits;
    logic [3:0]    r_code;

    kp_state_t     r_state;
    kp_state_t     w_state_nxt;
    logic [SW-1:0] r_stable;
    logic [SW-1:0] w_stable_nxt;
    logic [3:0]    r_cand;
    logic [3:0]    w_cand_nxt;
    logic          w_accept;
    logic [3:0]    w_accept_code;

    logic [31:0]   r_entry;
    logic [3:0]    r_digit_cnt;
    logic [3:0]    r_key_code;
    logic          r_key_pulse;
    logic [31:0]   r_data_out;
    logic          r_data_valid;

    logic          w_sample;
    logic          w_frame_end;
    logic [2:0]    w_row_hits;
    logic [1:0]    w_row_col;
    logic [2:0]    w_sum;
    logic [1:0]    w_frame_hits;
    logic [3:0]    w_frame_code;
    logic          w_key_vld;
    logic          w_conf_rise;
    logic          w_clr_rise;
    logic          w_confirm_level_unused;
    logic          w_clear_level_unused;

    assign w_sample    = (r_dwell == DW'(SCAN_CYCLES - 1));
    assign w_frame_end = w_sample && (r_row == 2'd3);

    always_comb begin
        w_row_hits = '0;
        w_row_col  = '0;
        for (int c = 0; c < 4; c++) begin
            if (!r_col_sync[c]) begin
                w_row_hits = w_row_hits + 3'd1;
                w_row_col  = 2'(c);
            end
        end
    end

    // Frame accumulation restarts at row 0; hit count saturates at 2 since any multi-press is rejected.
    always_comb begin
        w_sum        = ((r_row == 2'd0) ? 3'd0 : {1'b0, r_hits}) + w_row_hits;
        w_frame_hits = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        if (w_row_hits == 3'd1) begin
            w_frame_code = key_lookup(r_row, w_row_col);
        end else begin
            w_frame_code = (r_row == 2'd0) ? 4'h0 : r_code;
        end
    end

    assign w_key_vld = w_frame_end && (w_frame_hits == 2'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
            r_row      <= 2'd0;
            r_dwell    <= '0;
            r_hits     <= 2'd0;
            r_code     <= 4'h0;
        end else begin
            r_col_meta <= kp_col;
            r_col_sync <= r_col_meta;
            if (w_sample) begin
                r_dwell <= '0;
                r_row   <= r_row + 2'd1;
                r_hits  <= w_frame_hits;
                r_code  <= w_frame_code;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_stable <= '0;
            r_cand   <= 4'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_stable <= w_stable_nxt;
            r_cand   <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_stable_nxt  = r_stable;
        w_cand_nxt    = r_cand;
        w_accept      = 1'b0;
        w_accept_code = r_cand;
        if (w_frame_end) begin
            case (r_state)
                IDLE: begin
                    if (w_key_vld) begin
                        w_cand_nxt = w_frame_code;
                        if (SW'(1) == SW'(DEBOUNCE_FRAMES)) begin
                            w_accept      = 1'b1;
                            w_accept_code = w_frame_code;
                            w_state_nxt   = HELD;
                            w_stable_nxt  = '0;
                        end else begin
                            w_state_nxt  = PRESS_DB;
                            w_stable_nxt = SW'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (w_key_vld && (w_frame_code == r_cand)) begin
                        if (r_stable + 1'b1 == SW'(DEBOUNCE_FRAMES)) begin
                            w_accept     = 1'b1;
                            w_state_nxt  = HELD;
                            w_stable_nxt = '0;
                        end else begin
                            w_stable_nxt = r_stable + 1'b1;
                        end
                    end else begin
                        w_state_nxt  = IDLE;
                        w_stable_nxt = '0;
                    end
                end
                HELD: begin
                    if (!w_key_vld) begin
                        if (SW'(1) == SW'(DEBOUNCE_FRAMES)) begin
                            w_state_nxt  = IDLE;
                            w_stable_nxt = '0;
                        end else begin
                            w_state_nxt  = REL_DB;
                            w_stable_nxt = SW'(1);
                        end
                    end
                end
                REL_DB: begin
                    if (w_key_vld) begin
                        w_state_nxt  = HELD;
                        w_stable_nxt = '0;
                    end else if (r_stable + 1'b1 == SW'(DEBOUNCE_FRAMES)) begin
                        w_state_nxt  = IDLE;
                        w_stable_nxt = '0;
                    end else begin
                        w_stable_nxt = r_stable + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_stable_nxt = '0;
                end
            endcase
        end
    end

    btn_debounce #(.BTN_CYCLES(BTN_CYCLES)) u_confirm (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_confirm),
        .o_level (w_confirm_level_unused),
        .o_rise  (w_conf_rise)
    );

    btn_debounce #(.BTN_CYCLES(BTN_CYCLES)) u_clear (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_clear),
        .o_level (w_clear_level_unused),
        .o_rise  (w_clr_rise)
    );

    // Clear beats confirm beats key entry; a key arriving with either still updates key_code and pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry      <= '0;
            r_digit_cnt  <= '0;
            r_key_code   <= '0;
            r_key_pulse  <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_key_pulse  <= w_accept;
            r_data_valid <= 1'b0;
            if (w_accept) begin
                r_key_code <= w_accept_code;
            end
            if (w_clr_rise) begin
                r_entry     <= '0;
                r_digit_cnt <= '0;
            end else if (w_conf_rise) begin
                r_data_out   <= r_entry;
                r_data_valid <= 1'b1;
                r_entry      <= '0;
                r_digit_cnt  <= '0;
            end else if (w_accept && (r_digit_cnt < 4'(MAX_DIGITS))) begin
                r_entry     <= {r_entry[27:0], w_accept_code};
                r_digit_cnt <= r_digit_cnt + 4'd1;
            end
        end
    end

    assign kp_row     = ~(4'b0001 << r_row);
    assign entry      = r_entry;
    assign digit_cnt  = r_digit_cnt;
    assign key_code   = r_key_code;
    assign key_pulse  = r_key_pulse;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_keypad_input.sv
// Directed bench for keypad_input with a behavioural 4x4 matrix model (two simultaneous keys max).
module tb_keypad_input;

    localparam int SCAN  = 4;
    localparam int DEB   = 2;
    localparam int BTN   = 4;
    localparam int FRAME = 4 * SCAN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  kp_col;
    logic        btn_confirm = 1'b0;
    logic        btn_clear = 1'b0;
    logic [3:0]  kp_row;
    logic [31:0] entry;
    logic [3:0]  digit_cnt;
    logic [3:0]  key_code;
    logic        key_pulse;
    logic [31:0] data_out;
    logic        data_valid;

    logic        k0_en = 1'b0;
    logic        k1_en = 1'b0;
    logic [1:0]  k0_r = 2'd0;
    logic [1:0]  k0_c = 2'd0;
    logic [1:0]  k1_r = 2'd0;
    logic [1:0]  k1_c = 2'd0;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int dv_cnt = 0;

    always #5 clk = ~clk;

    keypad_input #(
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_FRAMES (DEB),
        .BTN_CYCLES      (BTN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kp_col      (kp_col),
        .btn_confirm (btn_confirm),
        .btn_clear   (btn_clear),
        .kp_row      (kp_row),
        .entry       (entry),
        .digit_cnt   (digit_cnt),
        .key_code    (key_code),
        .key_pulse   (key_pulse),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    // A pressed switch shorts its column low only while its row is driven low.
    always_comb begin
        kp_col = 4'hF;
        if (k0_en && !kp_row[k0_r]) kp_col[k0_c] = 1'b0;
        if (k1_en && !kp_row[k1_r]) kp_col[k1_c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_pulse === 1'b1) pulse_cnt++;
        if (data_valid === 1'b1) dv_cnt++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [1:0] r, input logic [1:0] c, input int frames);
        k0_r  = r;
        k0_c  = c;
        k0_en = 1'b1;
        wait_cycles(frames * FRAME);
        k0_en = 1'b0;
    endtask

    task automatic press_btn(input logic clr, input logic conf);
        btn_clear   = clr;
        btn_confirm = conf;
        wait_cycles(10);
        btn_clear   = 1'b0;
        btn_confirm = 1'b0;
        wait_cycles(12);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cycles(3);
        checks++; if (kp_row !== 4'b1110) begin errors++; $display("FAIL reset_kp_row: got %b expected %b", kp_row, 4'b1110); end
        checks++; if (entry !== 32'h0) begin errors++; $display("FAIL reset_entry: got %h expected %h", entry, 32'h0); end
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL reset_digit_cnt: got %0d expected 0", digit_cnt); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        checks++; if (key_pulse !== 1'b0) begin errors++; $display("FAIL reset_key_pulse: got %b expected 0", key_pulse); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h expected %h", data_out, 32'h0); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        rst = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_single_key;
        int p0;
        p0 = pulse_cnt;
        press_key(2'd1, 2'd2, 4);
        wait_cycles(6 * FRAME);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", pulse_cnt - p0); end
        checks++; if (key_code !== 4'h6) begin errors++; $display("FAIL single_code: got %h expected 6", key_code); end
        checks++; if (entry !== 32'h0000_0006) begin errors++; $display("FAIL single_entry: got %h expected %h", entry, 32'h6); end
        checks++; if (digit_cnt !== 4'd1) begin errors++; $display("FAIL single_digit_cnt: got %0d expected 1", digit_cnt); end
    endtask

    task automatic test_bounce;
        int p0;
        p0 = pulse_cnt;
        press_key(2'd0, 2'd0, 1);
        wait_cycles(FRAME);
        press_key(2'd0, 2'd0, 3);
        wait_cycles(6 * FRAME);
        checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", pulse_cnt - p0); end
        checks++; if (key_code !== 4'h1) begin errors++; $display("FAIL bounce_code: got %h expected 1", key_code); end
        checks++; if (entry !== 32'h0000_0061) begin errors++; $display("FAIL bounce_entry: got %h expected %h", entry, 32'h61); end
    endtask

    task automatic test_ghost;
        int p0;
        p0 = pulse_cnt;
        k0_r = 2'd3; k0_c = 2'd0;
        k1_r = 2'd0; k1_c = 2'd3;
        k0_en = 1'b1; k1_en = 1'b1;
        wait_cycles(5 * FRAME);
        k0_en = 1'b0; k1_en = 1'b0;
        wait_cycles(6 * FRAME);
        checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL ghost_pulses: got %0d expected 0", pulse_cnt - p0); end
        checks++; if (entry !== 32'h0000_0061) begin errors++; $display("FAIL ghost_entry: got %h expected %h", entry, 32'h61); end
    endtask

    task automatic test_full_entry;
        int p0;
        int d0;
        press_btn(1'b1, 1'b0);
        checks++; if (entry !== 32'h0) begin errors++; $display("FAIL clear_entry: got %h expected 0", entry); end
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL clear_digit_cnt: got %0d expected 0", digit_cnt); end
        p0 = pulse_cnt;
        for (int i = 0; i < 9; i++) begin
            press_key(2'(i / 3), 2'(i % 3), 4);
            wait_cycles(4 * FRAME);
        end
        checks++; if (pulse_cnt - p0 != 9) begin errors++; $display("FAIL full_pulses: got %0d expected 9", pulse_cnt - p0); end
        checks++; if (entry !== 32'h1234_5678) begin errors++; $display("FAIL full_entry: got %h expected %h", entry, 32'h12345678); end
        checks++; if (digit_cnt !== 4'd8) begin errors++; $display("FAIL full_digit_cnt: got %0d expected 8", digit_cnt); end
        checks++; if (key_code !== 4'h9) begin errors++; $display("FAIL full_code: got %h expected 9", key_code); end
        d0 = dv_cnt;
        press_btn(1'b0, 1'b1);
        checks++; if (dv_cnt - d0 != 1) begin errors++; $display("FAIL confirm_valid: got %0d strobes expected 1", dv_cnt - d0); end
        checks++; if (data_out !== 32'h1234_5678) begin errors++; $display("FAIL confirm_data: got %h expected %h", data_out, 32'h12345678); end
        checks++; if (entry !== 32'h0) begin errors++; $display("FAIL confirm_entry: got %h expected 0", entry); end
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL confirm_digit_cnt: got %0d expected 0", digit_cnt); end
    endtask

    task automatic test_clear_confirm;
        int d0;
        press_key(2'd0, 2'd3, 4);
        wait_cycles(4 * FRAME);
        press_key(2'd1, 2'd3, 4);
        wait_cycles(4 * FRAME);
        checks++; if (entry !== 32'h0000_00AB) begin errors++; $display("FAIL ab_entry: got %h expected %h", entry, 32'hAB); end
        d0 = dv_cnt;
        press_btn(1'b1, 1'b1);
        checks++; if (entry !== 32'h0) begin errors++; $display("FAIL both_entry: got %h expected 0", entry); end
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL both_digit_cnt: got %0d expected 0", digit_cnt); end
        checks++; if (dv_cnt - d0 != 0) begin errors++; $display("FAIL both_valid: got %0d strobes expected 0", dv_cnt - d0); end
        checks++; if (data_out !== 32'h1234_5678) begin errors++; $display("FAIL both_data: got %h expected %h", data_out, 32'h12345678); end
    endtask

    task automatic test_reset_mid_debounce;
        int p0;
        int n;
        n = 0;
        while (kp_row !== 4'b0111 && n < 64) begin wait_cycles(1); n++; end
        while (kp_row !== 4'b1110 && n < 64) begin wait_cycles(1); n++; end
        checks++; if (kp_row !== 4'b1110) begin errors++; $display("FAIL frame_sync: got %b expected %b", kp_row, 4'b1110); end
        p0 = pulse_cnt;
        // First frame end at cycle 15 enters PRESS_DB; acceptance would come at cycle 31.
        k0_r = 2'd2; k0_c = 2'd2; k0_en = 1'b1;
        wait_cycles(22);
        checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL pre_reset_pulses: got %0d expected 0", pulse_cnt - p0); end
        rst = 1'b1;
        k0_en = 1'b0;
        wait_cycles(3);
        checks++; if (kp_row !== 4'b1110) begin errors++; $display("FAIL mid_kp_row: got %b expected %b", kp_row, 4'b1110); end
        checks++; if (entry !== 32'h0) begin errors++; $display("FAIL mid_entry: got %h expected 0", entry); end
        checks++; if (digit_cnt !== 4'd0) begin errors++; $display("FAIL mid_digit_cnt: got %0d expected 0", digit_cnt); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL mid_key_code: got %h expected 0", key_code); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mid_data_out: got %h expected 0", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL mid_data_valid: got %b expected 0", data_valid); end
        rst = 1'b0;
        wait_cycles(4 * FRAME);
        checks++; if (pulse_cnt - p0 != 0) begin errors++; $display("FAIL post_reset_pulses: got %0d expected 0", pulse_cnt - p0); end
        checks++; if (key_pulse !== 1'b0) begin errors++; $display("FAIL post_reset_key_pulse: got %b expected 0", key_pulse); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_ghost();
        test_full_entry();
        test_clear_confirm();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
